// File: rtl/grad_spi_serialiser.sv
// Shifts per-channel grad_bram words out to N_CH SPI DACs: shared SCLK, one SDI and one SSN per channel.
// Latency: valid_i sampled at edge E0 -> SSN low and MSB on SDI after E1 when idle; otherwise after the current frame's gap.
// Backpressure: none; one shadow word per channel, and overwriting a pending word pulses data_lost_o.
module grad_spi_serialiser #(
  parameter int N_CH       = 4,
  parameter int FRAME_BITS = 24,
  parameter int DIV_W      = 6
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [31:0]       data_i,
  input  logic [N_CH-1:0]   valid_i,
  input  logic [DIV_W-1:0]  spi_clk_div_i,
  output logic              sclk_o,
  output logic [N_CH-1:0]   ssn_o,
  output logic [N_CH-1:0]   sdi_o,
  output logic              busy_o,
  output logic              data_lost_o
);

  localparam int BCW = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                state;
  logic [FRAME_BITS-1:0] shadow [N_CH];
  logic [FRAME_BITS-1:0] shift  [N_CH];
  logic [N_CH-1:0]       pend;
  logic [N_CH-1:0]       act;
  logic [N_CH-1:0]       consume;
  logic [DIV_W-1:0]      div_lat;
  logic [DIV_W-1:0]      h_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic                  half_done;
  logic                  start;
  logic                  unused_data_hi;

  // Only the payload bits travel over SPI; the upper bits of the word are ignored.
  assign unused_data_hi = &{1'b0, data_i[31:FRAME_BITS]};

  // A frame starts from IDLE at once, or straight out of GAP once its H cycles are spent.
  always_comb begin
    half_done = (h_cnt == div_lat);
    start     = 1'b0;
    if (|pend) begin
      start = (state == IDLE) || ((state == GAP) && half_done);
    end
    consume = start ? pend : '0;
  end

  // Shadow capture: a new word wins over the old one; loss only if the old one was not just taken by a frame.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int k = 0; k < N_CH; k++) shadow[k] <= '0;
      pend        <= '0;
      data_lost_o <= 1'b0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (valid_i[k]) shadow[k] <= data_i[FRAME_BITS-1:0];
      end
      pend        <= (pend & ~consume) | valid_i;
      data_lost_o <= |(valid_i & pend & ~consume);
    end
  end

  // Frame FSM: loads the shifters on start, generates SCLK from the latched divider, then idles SSN for one half-period.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state   <= IDLE;
      for (int k = 0; k < N_CH; k++) shift[k] <= '0;
      act     <= '0;
      div_lat <= '0;
      h_cnt   <= '0;
      bit_cnt <= '0;
      sclk_o  <= 1'b0;
      ssn_o   <= '1;
      sdi_o   <= '0;
      busy_o  <= 1'b0;
    end else if (start) begin
      state   <= SHIFT;
      act     <= pend;
      div_lat <= spi_clk_div_i;
      h_cnt   <= '0;
      bit_cnt <= '0;
      sclk_o  <= 1'b0;
      ssn_o   <= ~pend;
      busy_o  <= 1'b1;
      for (int k = 0; k < N_CH; k++) begin
        shift[k] <= pend[k] ? shadow[k] : '0;
        sdi_o[k] <= pend[k] & shadow[k][FRAME_BITS-1];
      end
    end else begin
      case (state)
        IDLE: begin
          busy_o <= 1'b0;
        end
        SHIFT: begin
          if (!half_done) begin
            h_cnt <= h_cnt + 1'b1;
          end else begin
            h_cnt <= '0;
            if (!sclk_o) begin
              sclk_o <= 1'b1;
            end else if (bit_cnt == BCW'(FRAME_BITS - 1)) begin
              sclk_o <= 1'b0;
              ssn_o  <= '1;
              sdi_o  <= '0;
              state  <= GAP;
            end else begin
              sclk_o  <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
              for (int k = 0; k < N_CH; k++) begin
                shift[k] <= {shift[k][FRAME_BITS-2:0], 1'b0};
                sdi_o[k] <= act[k] & shift[k][FRAME_BITS-2];
              end
            end
          end
        end
        GAP: begin
          if (!half_done) begin
            h_cnt <= h_cnt + 1'b1;
          end else begin
            h_cnt  <= '0;
            act    <= '0;
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grad_spi_serialiser.sv
// Bench for grad_spi_serialiser: drives grad_bram-style strobes and checks SPI frames against a scoreboard.
// Latency: frames are checked as they complete on the SPI pins; latency and busy length checked in-line.
// Backpressure: none at the DUT; overwrite loss pulses are counted by the monitor.
module tb_grad_spi_serialiser;

  typedef struct packed {
    logic [3:0]        mask;
    logic [3:0][23:0]  dat;
    int                h;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] data;
  logic [3:0]  valid;
  logic [5:0]  div;
  logic        sclk;
  logic [3:0]  ssn;
  logic [3:0]  sdi;
  logic        busy;
  logic        lost;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  grad_spi_serialiser #(.N_CH(4), .FRAME_BITS(24), .DIV_W(6)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .data_i        (data),
    .valid_i       (valid),
    .spi_clk_div_i (div),
    .sclk_o        (sclk),
    .ssn_o         (ssn),
    .sdi_o         (sdi),
    .busy_o        (busy),
    .data_lost_o   (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [3:0] mask, input logic [23:0] d, input int h);
    exp_t e;
    e.mask = mask;
    for (int k = 0; k < 4; k++) e.dat[k] = mask[k] ? d : 24'h0;
    e.h = h;
    return e;
  endfunction

  // ---------------- frame monitor ----------------
  logic        in_frame = 1'b0;
  logic        prev_sclk = 1'b0;
  logic [3:0]  f_mask;
  logic [23:0] acc [4];
  int          pulses, frame_cyc, hi_run, first_hi, bad;
  int          frames_started = 0;
  int          lost_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame  = 1'b0;
      prev_sclk = 1'b0;
    end else begin
      if (lost) lost_cnt++;
      if (!in_frame && ssn != 4'hf) begin
        in_frame  = 1'b1;
        f_mask    = ~ssn;
        for (int k = 0; k < 4; k++) acc[k] = '0;
        pulses    = 0;
        frame_cyc = 0;
        hi_run    = 0;
        first_hi  = 0;
        bad       = 0;
        frames_started++;
      end
      if (in_frame) begin
        if (ssn == 4'hf) begin
          in_frame = 1'b0;
          check("sb_frame_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("frame_mask", f_mask, e.mask);
            for (int k = 0; k < 4; k++)
              if (e.mask[k]) check($sformatf("frame_data_ch%0d", k), acc[k], e.dat[k]);
            check("frame_pulses", pulses, 24);
            check("frame_ssn_low_cycles", frame_cyc, 48 * e.h);
            check("frame_sclk_high_len", first_hi, e.h);
            check("frame_inactive_or_ssn_glitch", bad, 0);
            if (sclk) check("frame_end_sclk", sclk, 0);
          end
        end else begin
          frame_cyc++;
          if (ssn != ~f_mask) bad++;
          for (int k = 0; k < 4; k++) if (!f_mask[k] && sdi[k]) bad++;
          if (sclk && !prev_sclk) begin
            pulses++;
            for (int k = 0; k < 4; k++) acc[k] = {acc[k][22:0], sdi[k]};
          end
          if (sclk) hi_run++;
          else begin
            if (prev_sclk && first_hi == 0) first_hi = hi_run;
            hi_run = 0;
          end
        end
      end
      prev_sclk = sclk;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [3:0] m, input logic [31:0] d);
    valid = m;
    data  = d;
    @(negedge clk);
    valid = 4'h0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, n >= budget, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic busy_len(input string tag, input int exp_len);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_len);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int lost0;
    rst_n = 1'b0;
    valid = 4'h0;
    data  = 32'h0;
    div   = 6'd0;
    #12;
    check("rst_sclk", sclk, 0);
    check("rst_ssn", ssn, 4'hf);
    check("rst_sdi", sdi, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_lost", lost, 0);
    #10 rst_n = 1'b1;
    @(negedge clk);

    // 1: single channel, fastest clock
    div = 6'd0;
    sb_q.push_back(mk_exp(4'b0001, 24'habcdef, 1));
    send(4'b0001, 32'h00abcdef);
    check("t1_ssn_before_start", ssn, 4'hf);
    @(negedge clk);
    check("t1_ssn_latency", ssn, 4'b1110);
    check("t1_sdi_msb", sdi, 4'b0001);
    busy_len("t1_busy_len", 49);
    check("t1_lost", lost_cnt, 0);
    wait_idle("t1", 200);

    // 2: broadcast to all channels, slow clock
    div = 6'd30;
    sb_q.push_back(mk_exp(4'b1111, 24'hfe1234, 31));
    send(4'b1111, 32'hcafe1234);
    @(negedge clk);
    check("t2_ssn_all_low", ssn, 4'b0000);
    busy_len("t2_busy_len", 1488 + 31);
    wait_idle("t2", 200);

    // 3: overwrite of a pending word, next frame directly after gap
    div = 6'd30;
    sb_q.push_back(mk_exp(4'b0001, 24'h5a5a5a, 31));
    send(4'b0001, 32'h005a5a5a);
    repeat (20) @(negedge clk);
    send(4'b0010, 32'h00111111);
    check("t3_no_lost_first", lost, 0);
    repeat (20) @(negedge clk);
    sb_q.push_back(mk_exp(4'b0010, 24'h222222, 31));
    send(4'b0010, 32'h00222222);
    check("t3_lost_pulse", lost, 1);
    @(negedge clk);
    check("t3_lost_single", lost, 0);
    n = 0;
    while (ssn != 4'hf && n < 3000) begin @(negedge clk); n++; end
    n = 0;
    while (ssn == 4'hf && n < 200) begin @(negedge clk); n++; end
    check("t3_gap_len", n, 31);
    check("t3_next_ssn", ssn, 4'b1101);
    wait_idle("t3", 4000);
    check("t3_lost_total", lost_cnt, 1);

    // 4: new word on the exact edge that consumes the pending one
    lost0 = lost_cnt;
    div = 6'd0;
    sb_q.push_back(mk_exp(4'b0001, 24'h0a0a0a, 1));
    sb_q.push_back(mk_exp(4'b0100, 24'h0b0b0b, 1));
    sb_q.push_back(mk_exp(4'b0100, 24'h0c0c0c, 1));
    send(4'b0001, 32'h000a0a0a);
    repeat (4) @(negedge clk);
    send(4'b0100, 32'h000b0b0b);
    n = 0;
    while (!(ssn == 4'hf && busy) && n < 500) begin @(negedge clk); n++; end
    check("t4_gap_found", n < 500, 1);
    send(4'b0100, 32'hff0c0c0c);
    wait_idle("t4", 500);
    check("t4_no_loss", lost_cnt, lost0);

    // 5: async reset mid-frame discards everything
    div = 6'd30;
    send(4'b1111, 32'h00777777);
    repeat (10) @(negedge clk);
    send(4'b0001, 32'h00123456);
    repeat (90) @(negedge clk);
    check("t5_in_shift", busy, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_sclk", sclk, 0);
    check("t5_rst_ssn", ssn, 4'hf);
    check("t5_rst_sdi", sdi, 4'h0);
    check("t5_rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    n = frames_started;
    repeat (300) @(negedge clk);
    check("t5_no_frame_after_reset", frames_started, n);
    check("t5_busy_low", busy, 0);
    check("t5_ssn_high", ssn, 4'hf);

    // 6: divider change mid-frame only applies to the next frame
    div = 6'd30;
    sb_q.push_back(mk_exp(4'b0001, 24'h0f0f0f, 31));
    sb_q.push_back(mk_exp(4'b0001, 24'hf0f0f0, 1));
    send(4'b0001, 32'h000f0f0f);
    repeat (10) @(negedge clk);
    div = 6'd0;
    send(4'b0001, 32'h00f0f0f0);
    wait_idle("t6", 4000);

    check("sb_drained", sb_q.size(), 0);
    check("lost_total", lost_cnt, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
